// File: rtl/axis_output_packetizer.sv
// axis_output_packetizer: streams six header words then BRAM payload words on AXI4-Stream.
// PACKETIZER_CHECKSUM_EN appends a payload-sum trailer word carrying tlast.
module axis_output_packetizer #(
  parameter int DW         = 16,
  parameter int BRAM_COUNT = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int BRAM_DEPTH = 512
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [DW-1:0]            header_word_0,
  input  logic [DW-1:0]            header_word_1,
  input  logic [DW-1:0]            header_word_2,
  input  logic [DW-1:0]            header_word_3,
  input  logic [DW-1:0]            header_word_4,
  input  logic [DW-1:0]            header_word_5,
  input  logic [2:0]               rd_bram_start,
  input  logic [2:0]               rd_bram_end,
  input  logic [15:0]              rd_addr_count,
  input  logic [BRAM_COUNT*DW-1:0] bram_rd_data_flat,
  output logic [ADDR_WIDTH-1:0]    bram_rd_addr,
  output logic                     bram_rd_en,
  output logic [DW-1:0]            m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done,
  output logic                     error_range
);
  localparam logic [2:0] S_IDLE = 3'd0, S_HDR = 3'd1, S_PAY = 3'd2, S_TRL = 3'd3, S_FIN = 3'd4;
`ifdef PACKETIZER_CHECKSUM_EN
  localparam logic [2:0] S_NEXT = S_TRL;
  logic [DW-1:0] sum_q;
`else
  localparam logic [2:0] S_NEXT = S_FIN;
`endif
  logic [2:0] state_q, state_d, hidx_q, bram_q, end_q, infl_b_q;
  logic [DW-1:0] hdr_q [5];
  logic [DW-1:0] fifo_q [2];
  logic [DW-1:0] tdata_q, rdata, head;
  logic [15:0] addr_q, cnt_q;
  logic [19:0] total_q, beat_q;
  logic [3:0] nb;
  logic [1:0] occ_q;
  logic seq_q, infl_q, err_q, plast_q, tvalid_q, tlast_q, wp_q, rp_q;
  logic hs, bad, accept, issue, avail, load, pop, popf, push, last_hs, is_last, addr_last, bram_last;
  assign hs        = tvalid_q && m_axis_tready;
  assign bad       = rd_bram_start > rd_bram_end || 32'(rd_bram_end) >= BRAM_COUNT ||
                     rd_addr_count == 16'd0 || 32'(rd_addr_count) > BRAM_DEPTH;
  assign accept    = state_q == S_IDLE && start && !bad;
  // occupancy counts the FIFO plus the read in flight; the output register is the third slot
  assign issue     = seq_q && (occ_q == 2'd0 || (occ_q == 2'd1 && !infl_q));
  assign rdata     = bram_rd_data_flat[infl_b_q*DW +: DW];
  assign head      = occ_q != 2'd0 ? fifo_q[rp_q] : rdata;
  assign avail     = occ_q != 2'd0 || infl_q;
  assign load      = (state_q == S_HDR && hs && hidx_q == 3'd5) ||
                     (state_q == S_PAY && (!tvalid_q || m_axis_tready) && !plast_q);
  assign pop       = load && avail;
  assign popf      = pop && occ_q != 2'd0;
  assign push      = infl_q && !(pop && occ_q == 2'd0);
  assign last_hs   = state_q == S_PAY && hs && plast_q;
  assign is_last   = beat_q == total_q - 20'd1;
  assign addr_last = addr_q == cnt_q - 16'd1;
  assign bram_last = bram_q == end_q;
  assign nb        = 4'(rd_bram_end) - 4'(rd_bram_start) + 4'd1;
  assign bram_rd_en    = issue;
  assign bram_rd_addr  = addr_q[ADDR_WIDTH-1:0];
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = state_q != S_IDLE && state_q != S_FIN;
  assign done          = state_q == S_FIN || err_q;
  assign error_range   = err_q;
  always_comb begin
    state_d = state_q;
    if (accept) state_d = S_HDR;
    if (state_q == S_HDR && hs && hidx_q == 3'd5) state_d = S_PAY;
    if (last_hs) state_d = S_NEXT;
`ifdef PACKETIZER_CHECKSUM_EN
    if (state_q == S_TRL && hs) state_d = S_FIN;
`endif
    if (state_q == S_FIN) state_d = S_IDLE;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      seq_q    <= 1'b0;
      infl_q   <= 1'b0;
      infl_b_q <= 3'd0;
      addr_q   <= 16'd0;
      bram_q   <= 3'd0;
      occ_q    <= 2'd0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      plast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      err_q    <= state_q == S_IDLE && start && bad;
      infl_q   <= issue;
      infl_b_q <= bram_q;
      if (accept) begin
        hdr_q    <= '{header_word_1, header_word_2, header_word_3, header_word_4, header_word_5};
        end_q    <= rd_bram_end;
        cnt_q    <= rd_addr_count;
        total_q  <= 20'(nb) * 20'(rd_addr_count);
        bram_q   <= rd_bram_start;
        addr_q   <= 16'd0;
        seq_q    <= 1'b1;
        hidx_q   <= 3'd0;
        beat_q   <= 20'd0;
        plast_q  <= 1'b0;
        tvalid_q <= 1'b1;
        tlast_q  <= 1'b0;
        tdata_q  <= header_word_0;
`ifdef PACKETIZER_CHECKSUM_EN
        sum_q    <= '0;
`endif
      end
      if (issue) begin
        addr_q <= addr_last ? 16'd0 : addr_q + 16'd1;
        if (addr_last && bram_last) seq_q <= 1'b0;
        if (addr_last && !bram_last) bram_q <= bram_q + 3'd1;
      end
      if (push) begin
        fifo_q[wp_q] <= rdata;
        wp_q <= ~wp_q;
      end
      if (popf) rp_q <= ~rp_q;
      occ_q <= occ_q + 2'(push) - 2'(popf);
      if (state_q == S_HDR && hs && hidx_q != 3'd5) begin
        tdata_q <= hdr_q[0];
        hdr_q   <= '{hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[4]};
        hidx_q  <= hidx_q + 3'd1;
      end
      if (load) begin
        tvalid_q <= avail;
        if (avail) begin
          tdata_q <= head;
          plast_q <= is_last;
          beat_q  <= beat_q + 20'd1;
`ifdef PACKETIZER_CHECKSUM_EN
          sum_q   <= sum_q + head;
`else
          tlast_q <= is_last;
`endif
        end
      end
`ifdef PACKETIZER_CHECKSUM_EN
      if (last_hs) begin
        tdata_q <= sum_q;
        tlast_q <= 1'b1;
      end
      if (state_q == S_TRL && hs) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
`else
      if (last_hs) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
`endif
    end
  end
endmodule
